// File: rtl/priority_dispatch_pkg.sv
// priority_dispatch_pkg: shared constants and lowest-one grant helper for priority_dispatch
package priority_dispatch_pkg;
    localparam int STAT_CNT_WIDTH = 16;
    localparam int BUF_DEPTH = 2;
    function automatic logic [31:0] lowest_one(input logic [31:0] x);
        return x & ~(x - 32'd1);
    endfunction
endpackage

// File: rtl/priority_dispatch_buf.sv
// priority_dispatch_buf: 2-entry input FIFO with push/pop, occupancy count and head word
module priority_dispatch_buf
    import priority_dispatch_pkg::*;
#(
    parameter int DataWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DataWidth-1:0] push_data,
    output logic [DataWidth-1:0] head,
    output logic [1:0]           count
);
    logic [DataWidth-1:0] mem [BUF_DEPTH];
    logic                 rd_ptr;
    logic                 wr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/priority_dispatch.sv
// priority_dispatch: FIFO-buffered dispatch of words to the lowest-index eligible output slot; PRIORITY_DISPATCH_STATS_EN adds per-channel dispatch counters
module priority_dispatch
    import priority_dispatch_pkg::*;
#(
    parameter int OutputWidth = 4,
    parameter int DataWidth   = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic [DataWidth-1:0]                   in_data_i,
    input  logic [OutputWidth-1:0]                 chan_en_i,
    output logic [OutputWidth-1:0]                 out_valid_o,
    input  logic [OutputWidth-1:0]                 out_ready_i,
    output logic [OutputWidth-1:0][DataWidth-1:0]  out_data_o,
    output logic                                   busy_o
`ifdef PRIORITY_DISPATCH_STATS_EN
    ,
    output logic [OutputWidth-1:0][STAT_CNT_WIDTH-1:0] disp_cnt_o
`endif
);
    logic [1:0]             count;
    logic [DataWidth-1:0]   head;
    logic [OutputWidth-1:0] elig;
    logic [OutputWidth-1:0] grant;
    logic                   push;
    logic                   pop;

    // in_ready_o depends only on the registered occupancy
    assign in_ready_o = (count != 2'(BUF_DEPTH));
    assign push       = in_valid_i & in_ready_o;
    assign elig       = chan_en_i & (~out_valid_o | out_ready_i);
    assign grant      = (count != 2'd0) ? OutputWidth'(lowest_one(32'(elig))) : '0;
    assign pop        = |grant;
    assign busy_o     = (count != 2'd0) | (|out_valid_o);

    priority_dispatch_buf #(.DataWidth(DataWidth)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .push_data(in_data_i),
        .head     (head),
        .count    (count)
    );

    // A granted slot is refilled even if it is being drained the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_o <= '0;
            out_data_o  <= '0;
        end else begin
            for (int i = 0; i < OutputWidth; i++) begin
                if (grant[i]) begin
                    out_valid_o[i] <= 1'b1;
                    out_data_o[i]  <= head;
                end else if (out_ready_i[i]) begin
                    out_valid_o[i] <= 1'b0;
                end
            end
        end
    end

`ifdef PRIORITY_DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_cnt_o <= '0;
        end else begin
            for (int i = 0; i < OutputWidth; i++) disp_cnt_o[i] <= disp_cnt_o[i] + STAT_CNT_WIDTH'(grant[i]);
        end
    end
`endif
endmodule

// File: tb/tb_priority_dispatch.sv
// tb_priority_dispatch: directed vector table plus hand-written sequences for priority_dispatch
module tb_priority_dispatch;
    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic [3:0]       chan_en;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [3:0][7:0]  out_data;
    logic             busy;
`ifdef PRIORITY_DISPATCH_STATS_EN
    logic [3:0][15:0] disp_cnt;
`endif
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    priority_dispatch #(.OutputWidth(4), .DataWidth(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .chan_en_i  (chan_en),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .busy_o     (busy)
`ifdef PRIORITY_DISPATCH_STATS_EN
        ,
        .disp_cnt_o (disp_cnt)
`endif
    );

    typedef struct {
        logic        rst_n;
        logic        in_valid;
        logic [7:0]  in_data;
        logic [3:0]  chan_en;
        logic [3:0]  out_ready;
        logic        exp_ready;
        logic [3:0]  exp_valid;
        logic [31:0] exp_data;
        logic        exp_busy;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic [3:0] en, input logic [3:0] rdy);
        rst_n = r; in_valid = v; in_data = d; chan_en = en; out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] m;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; chan_en = '0; out_ready = '0;
        vt[0]  = '{1'b0, 1'b0, 8'h00, 4'hF, 4'h0, 1'b1, 4'h0, 32'h00000000, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 8'hA1, 4'hF, 4'h0, 1'b1, 4'h0, 32'h00000000, 1'b1};
        vt[2]  = '{1'b1, 1'b1, 8'hA2, 4'hF, 4'h0, 1'b1, 4'h1, 32'h000000A1, 1'b1};
        vt[3]  = '{1'b1, 1'b0, 8'h00, 4'hF, 4'h0, 1'b1, 4'h3, 32'h0000A2A1, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 8'h00, 4'hF, 4'h0, 1'b1, 4'h3, 32'h0000A2A1, 1'b1};
        vt[5]  = '{1'b1, 1'b1, 8'hC2, 4'hF, 4'h0, 1'b1, 4'h3, 32'h0000A2A1, 1'b1};
        vt[6]  = '{1'b1, 1'b1, 8'hC3, 4'hF, 4'h0, 1'b1, 4'h7, 32'h00C2A2A1, 1'b1};
        vt[7]  = '{1'b1, 1'b1, 8'hB0, 4'hF, 4'h0, 1'b1, 4'hF, 32'hC3C2A2A1, 1'b1};
        vt[8]  = '{1'b1, 1'b1, 8'hB1, 4'hF, 4'h0, 1'b0, 4'hF, 32'hC3C2A2A1, 1'b1};
        vt[9]  = '{1'b1, 1'b1, 8'hB2, 4'hF, 4'h0, 1'b0, 4'hF, 32'hC3C2A2A1, 1'b1};
        vt[10] = '{1'b1, 1'b1, 8'hB2, 4'hF, 4'h1, 1'b1, 4'hF, 32'hC3C2A2B0, 1'b1};
        vt[11] = '{1'b1, 1'b1, 8'hB2, 4'hF, 4'h0, 1'b0, 4'hF, 32'hC3C2A2B0, 1'b1};
        vt[12] = '{1'b1, 1'b0, 8'h00, 4'hF, 4'h2, 1'b1, 4'hF, 32'hC3C2B1B0, 1'b1};
        vt[13] = '{1'b1, 1'b0, 8'h00, 4'hF, 4'h4, 1'b1, 4'hF, 32'hC3B2B1B0, 1'b1};
        vt[14] = '{1'b1, 1'b0, 8'h00, 4'h0, 4'hF, 1'b1, 4'h0, 32'h00000000, 1'b0};
        vt[15] = '{1'b1, 1'b1, 8'hD0, 4'hF, 4'h0, 1'b1, 4'h0, 32'h00000000, 1'b1};
        vt[16] = '{1'b1, 1'b1, 8'hD1, 4'hF, 4'h0, 1'b1, 4'h1, 32'h000000D0, 1'b1};
        vt[17] = '{1'b1, 1'b1, 8'hD2, 4'h0, 4'h0, 1'b0, 4'h1, 32'h000000D0, 1'b1};
        vt[18] = '{1'b0, 1'b1, 8'hD3, 4'hF, 4'hF, 1'b1, 4'h0, 32'h00000000, 1'b0};
        vt[19] = '{1'b1, 1'b0, 8'h00, 4'hF, 4'h0, 1'b1, 4'h0, 32'h00000000, 1'b0};
        @(posedge clk);
        #1;
        for (int k = 0; k < 20; k++) begin
            drive(vt[k].rst_n, vt[k].in_valid, vt[k].in_data, vt[k].chan_en, vt[k].out_ready);
            for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{vt[k].exp_valid[i]}};
            chk($sformatf("v%0d in_ready", k), 64'(in_ready), 64'(vt[k].exp_ready));
            chk($sformatf("v%0d out_valid", k), 64'(out_valid), 64'(vt[k].exp_valid));
            chk($sformatf("v%0d out_data", k), 64'(out_data & m), 64'(vt[k].exp_data & m));
            chk($sformatf("v%0d busy", k), 64'(busy), 64'(vt[k].exp_busy));
            if (!vt[k].rst_n) chk($sformatf("v%0d rst_data", k), 64'(out_data), 64'h0);
        end
        // stream to channel 1 only, one word per cycle after one cycle of latency
        for (int c = 0; c < 19; c++) begin
            drive(1'b1, c < 16, 8'(c), 4'b1010, 4'hF);
            chk($sformatf("stream c%0d valid", c), 64'(out_valid), (c >= 1 && c <= 16) ? 64'h2 : 64'h0);
            chk($sformatf("stream c%0d ready", c), 64'(in_ready), 64'h1);
            if (c >= 1 && c <= 16) chk($sformatf("stream c%0d data", c), 64'(out_data[1]), 64'(c - 1));
        end
        // refill of a draining slot without a bubble
        drive(1'b0, 1'b0, 8'h00, 4'h1, 4'h0);
        drive(1'b1, 1'b1, 8'hE0, 4'h1, 4'h0);
        drive(1'b1, 1'b1, 8'hE1, 4'h1, 4'h0);
        chk("refill first valid", 64'(out_valid), 64'h1);
        chk("refill first data", 64'(out_data[0]), 64'hE0);
        drive(1'b1, 1'b0, 8'h00, 4'h1, 4'h1);
        chk("refill valid", 64'(out_valid), 64'h1);
        chk("refill data", 64'(out_data[0]), 64'hE1);
        drive(1'b1, 1'b0, 8'h00, 4'h1, 4'h0);
        chk("refill hold data", 64'(out_data[0]), 64'hE1);
        chk("refill busy", 64'(busy), 64'h1);
`ifdef PRIORITY_DISPATCH_STATS_EN
        drive(1'b0, 1'b0, 8'h00, 4'h0, 4'h0);
        chk("stats reset", 64'(disp_cnt), 64'h0);
        for (int n = 0; n < 65537; n++) drive(1'b1, 1'b1, 8'(n), 4'b0100, 4'hF);
        for (int n = 0; n < 3; n++) drive(1'b1, 1'b0, 8'h00, 4'b0100, 4'hF);
        chk("stats ch2 wrap", 64'(disp_cnt[2]), 64'h1);
        chk("stats others", 64'({disp_cnt[3], disp_cnt[1], disp_cnt[0]}), 64'h0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
